// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter that serialises single read/write commands onto the 8x8 register bank.
// Optional requester locking is compiled in with `define REGBANK_ARB_LOCK_EN.
module regbank_arbiter #(
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int LOCK_TO = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
`ifdef REGBANK_ARB_LOCK_EN
  input  logic          a_lock,
  input  logic          b_lock,
`endif
  output logic          bank_we,
  output logic [AW-1:0] bank_write_addr,
  output logic [AW-1:0] bank_read_addr,
  output logic [DW-1:0] bank_write_data,
  input  logic [DW-1:0] bank_read_data
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state, state_next;
  logic            latch;
  logic            a_elig, b_elig;
  logic            winner;
  logic            prio_b;
  logic            cmd_we, cmd_owner;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            timeout_release, timeout_prio_b;

`ifdef REGBANK_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TO + 1);

  logic          lock_active, lock_owner;
  logic [CW-1:0] idle_cnt;
  logic          holder_req, win_lock;

  // While a lock is held only its owner is eligible for arbitration.
  assign a_elig          = a_req && (!lock_active || !lock_owner);
  assign b_elig          = b_req && (!lock_active ||  lock_owner);
  assign holder_req      = lock_owner ? b_req : a_req;
  assign win_lock        = winner ? b_lock : a_lock;
  assign timeout_release = lock_active && !holder_req && (idle_cnt == CW'(LOCK_TO - 1));
  assign timeout_prio_b  = !lock_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      idle_cnt    <= '0;
    end else if (latch) begin
      idle_cnt <= '0;
      if (win_lock) begin
        lock_active <= 1'b1;
        lock_owner  <= winner;
      end else begin
        lock_active <= 1'b0;
      end
    end else if (lock_active) begin
      if (holder_req) begin
        idle_cnt <= '0;
      end else if (timeout_release) begin
        lock_active <= 1'b0;
        idle_cnt    <= '0;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end
`else
  assign a_elig          = a_req;
  assign b_elig          = b_req;
  // No lock hardware in this build; LOCK_TO only ties off the release path.
  assign timeout_release = (LOCK_TO < 0);
  assign timeout_prio_b  = 1'b0;
`endif

  assign winner    = b_elig && (!a_elig || prio_b);
  assign win_we    = winner ? b_we    : a_we;
  assign win_addr  = winner ? b_addr  : a_addr;
  assign win_wdata = winner ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    bank_we    = 1'b0;
    case (state)
      IDLE: begin
        if (a_elig || b_elig) begin
          latch      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = IDLE;
        a_gnt      = !cmd_owner;
        b_gnt      =  cmd_owner;
        bank_we    =  cmd_we;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bank address/data registers only change for their own command type, so they hold between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we          <= 1'b0;
      cmd_owner       <= 1'b0;
      prio_b          <= 1'b0;
      bank_write_addr <= '0;
      bank_write_data <= '0;
      bank_read_addr  <= '0;
      a_rdata         <= '0;
      b_rdata         <= '0;
      a_rvalid        <= 1'b0;
      b_rvalid        <= 1'b0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (latch) begin
        cmd_we    <= win_we;
        cmd_owner <= winner;
        prio_b    <= !winner;
        if (win_we) begin
          bank_write_addr <= win_addr;
          bank_write_data <= win_wdata;
        end else begin
          bank_read_addr <= win_addr;
        end
      end else if (timeout_release) begin
        prio_b <= timeout_prio_b;
      end
      if (state == ISSUE && !cmd_we) begin
        if (cmd_owner) begin
          b_rdata  <= bank_read_data;
          b_rvalid <= 1'b1;
        end else begin
          a_rdata  <= bank_read_data;
          a_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: vector table, corner-case sequences and a read-data scoreboard.
// The lock sequences are only built when REGBANK_ARB_LOCK_EN is defined.
module tb_regbank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, bank_we;
  logic [7:0] a_rdata, b_rdata, bank_write_data, bank_read_data;
  logic [2:0] bank_write_addr, bank_read_addr;
`ifdef REGBANK_ARB_LOCK_EN
  logic       a_lock = 1'b0, b_lock = 1'b0;
`endif

  typedef struct {
    bit         who;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t       vecs[10];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] hold_a = '0, hold_b = '0;
  logic [7:0] mem[0:7] = '{default: 8'h00};

  always #5 clk = ~clk;

  regbank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef REGBANK_ARB_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .bank_we(bank_we), .bank_write_addr(bank_write_addr), .bank_read_addr(bank_read_addr),
    .bank_write_data(bank_write_data), .bank_read_data(bank_read_data)
  );

  // Behavioural register bank: synchronous write, combinational read.
  always @(posedge clk) if (bank_we) mem[bank_write_addr] <= bank_write_data;
  assign bank_read_data = mem[bank_read_addr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rvalid pops the next expected value; rdata must hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rvalid) begin
        if (qa.size() == 0) check_output("a_rvalid_unexpected", 32'(a_rvalid), 32'd0);
        else begin
          hold_a = qa.pop_front();
          check_output("a_rdata", 32'(a_rdata), 32'(hold_a));
        end
      end else check_output("a_rdata_hold", 32'(a_rdata), 32'(hold_a));
      if (b_rvalid) begin
        if (qb.size() == 0) check_output("b_rvalid_unexpected", 32'(b_rvalid), 32'd0);
        else begin
          hold_b = qb.pop_front();
          check_output("b_rdata", 32'(b_rdata), 32'(hold_b));
        end
      end else check_output("b_rdata_hold", 32'(b_rdata), 32'(hold_b));
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_gnt"},    32'({a_gnt, b_gnt}), 32'd0);
    check_output({tag, "_rvalid"}, 32'({a_rvalid, b_rvalid}), 32'd0);
    check_output({tag, "_rdata"},  32'({a_rdata, b_rdata}), 32'd0);
    check_output({tag, "_bank_we"}, 32'(bank_we), 32'd0);
    check_output({tag, "_bank_bus"}, 32'({bank_write_addr, bank_read_addr, bank_write_data}), 32'd0);
  endtask

  // Single command from one requester; entered just after a rising edge with the arbiter idle.
  task automatic apply_stimulus(input vec_t v);
    if (!v.who) begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
      if (!v.we) qa.push_back(v.exp_rdata);
    end else begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
      if (!v.we) qb.push_back(v.exp_rdata);
    end
    @(negedge clk);
    check_output("gnt_early", 32'(v.who ? b_gnt : a_gnt), 32'd0);
    @(posedge clk); #1;
    if (!v.who) a_req = 1'b0; else b_req = 1'b0;
    @(negedge clk);
    check_output("gnt_own",   32'(v.who ? b_gnt : a_gnt), 32'd1);
    check_output("gnt_other", 32'(v.who ? a_gnt : b_gnt), 32'd0);
    check_output("bank_we",   32'(bank_we), 32'(v.we));
    if (v.we) begin
      check_output("bank_write_addr", 32'(bank_write_addr), 32'(v.addr));
      check_output("bank_write_data", 32'(bank_write_data), 32'(v.wdata));
    end else begin
      check_output("bank_read_addr", 32'(bank_read_addr), 32'(v.addr));
    end
    @(posedge clk); #1;
    if (!v.we) begin
      @(negedge clk);
      check_output("rvalid_own",   32'(v.who ? b_rvalid : a_rvalid), 32'd1);
      check_output("rvalid_other", 32'(v.who ? a_rvalid : b_rvalid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Both requesters raise a command in the same cycle; A is expected to win the tie.
  task automatic apply_pair(input vec_t va, input vec_t vb);
    a_req = 1'b1; a_we = va.we; a_addr = va.addr; a_wdata = va.wdata;
    b_req = 1'b1; b_we = vb.we; b_addr = vb.addr; b_wdata = vb.wdata;
    if (!va.we) qa.push_back(va.exp_rdata);
    if (!vb.we) qb.push_back(vb.exp_rdata);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check_output("pair_first_gnt", 32'({a_gnt, b_gnt}), 32'b10);
    check_output("pair_first_we",  32'(bank_we), 32'(va.we));
    @(posedge clk); #1;
    @(negedge clk);
    check_output("pair_gap_gnt", 32'({a_gnt, b_gnt}), 32'b00);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    check_output("pair_second_gnt", 32'({a_gnt, b_gnt}), 32'b01);
    check_output("pair_second_we",  32'(bank_we), 32'(vb.we));
    if (vb.we) check_output("pair_second_wdata", 32'(bank_write_data), 32'(vb.wdata));
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 3'd3, 8'hAA, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 3'd3, 8'h00, 8'hAA};
    vecs[2] = '{1'b1, 1'b1, 3'd0, 8'h11, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h11};
    vecs[4] = '{1'b0, 1'b1, 3'd7, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 3'd7, 8'h00, 8'hFF};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h11};
    vecs[7] = '{1'b1, 1'b1, 3'd3, 8'h3C, 8'h00};
    vecs[8] = '{1'b0, 1'b0, 3'd3, 8'h00, 8'h3C};
    vecs[9] = '{1'b1, 1'b0, 3'd1, 8'h00, 8'h00};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);

    $display("[TB] simultaneous writes to the same register");
    apply_pair('{1'b0, 1'b1, 3'd5, 8'h55, 8'h00}, '{1'b1, 1'b1, 3'd5, 8'hA3, 8'h00});
    apply_stimulus('{1'b0, 1'b0, 3'd5, 8'h00, 8'hA3});
    apply_stimulus('{1'b1, 1'b0, 3'd5, 8'h00, 8'hA3});

    $display("[TB] both requesters hold reads");
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd7;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("alt_gnt", 32'({a_gnt, b_gnt}), (k % 2 == 0) ? 32'b10 : 32'b01);
      if (k % 2 == 0) qa.push_back(8'h3C); else qb.push_back(8'hFF);
      if (k == 3) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end else @(posedge clk);
    end
    @(posedge clk); #1;

    $display("[TB] request held after grant");
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0;
    @(negedge clk);
    check_output("held_gnt_n", 32'(a_gnt), 32'd0);
    @(posedge clk); @(negedge clk);
    check_output("held_gnt_n1", 32'(a_gnt), 32'd1);
    qa.push_back(8'h11);
    @(posedge clk); @(negedge clk);
    check_output("held_gnt_n2", 32'(a_gnt), 32'd0);
    @(posedge clk); @(negedge clk);
    check_output("held_gnt_n3", 32'(a_gnt), 32'd1);
    qa.push_back(8'h11);
    a_req = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset during a write");
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd3; a_wdata = 8'h99;
    @(posedge clk); #1;
    a_req = 1'b0;
    check_output("rst_pre_we", 32'(bank_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_drop_we",  32'(bank_we), 32'd0);
    check_output("rst_drop_gnt", 32'(a_gnt), 32'd0);
    qa.delete();
    qb.delete();
    hold_a = '0;
    hold_b = '0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_pair('{1'b0, 1'b0, 3'd3, 8'h00, 8'h3C}, '{1'b1, 1'b0, 3'd0, 8'h00, 8'h11});

`ifdef REGBANK_ARB_LOCK_EN
    $display("[TB] lock released by final access");
    a_lock = 1'b1;
    apply_stimulus('{1'b0, 1'b0, 3'd7, 8'h00, 8'hFF});
    a_lock = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd5;
    repeat (6) begin
      @(negedge clk);
      check_output("lock_block", 32'(b_gnt), 32'd0);
    end
    @(posedge clk); #1;
    apply_stimulus('{1'b0, 1'b1, 3'd1, 8'h5A, 8'h00});
    @(negedge clk);
    check_output("lock_release_gap", 32'(b_gnt), 32'd0);
    @(posedge clk); @(negedge clk);
    check_output("lock_release_gnt", 32'(b_gnt), 32'd1);
    qb.push_back(8'hA3);
    b_req = 1'b0;
    @(posedge clk); #1;

    $display("[TB] lock released by idle timeout");
    a_lock = 1'b1;
    apply_stimulus('{1'b0, 1'b0, 3'd5, 8'h00, 8'hA3});
    a_lock = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd7;
    begin
      int  wait_cnt = 0;
      bit  found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (b_gnt) found = 1'b1;
        else wait_cnt++;
      end
      check_output("timeout_gnt_seen", 32'(found), 32'd1);
      check_output("timeout_wait", 32'(wait_cnt), 32'd15);
      if (found) qb.push_back(8'hFF);
      b_req = 1'b0;
    end
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("qa_drained", 32'(qa.size()), 32'd0);
    check_output("qb_drained", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
Two-requester round-robin arbiter and access sequencer for the 8x8 register bank. The bank has one write port and one read port. Each requester issues single read or write commands through a req/gnt handshake. The arbiter serialises these commands onto the bank ports and returns read data with a valid strobe. It sits between the bank and its two clients (e.g. control unit and debug/loader port).

Parameters:
AW, 3, address width (bank depth 2**AW)
DW, 8, data width
LOCK_TO, 16, idle-cycle timeout that releases a lock (used only with REGBANK_ARB_LOCK_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_req  in  1  requester A command valid
a_we  in  1  A command type: 1 = write, 0 = read
a_addr  in  AW  A register address
a_wdata  in  DW  A write data
a_gnt  out  1  A command accepted (one-cycle pulse)
a_rvalid  out  1  A read data valid (one-cycle pulse)
a_rdata  out  DW  A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
bank_we  out  1  to bank we
bank_write_addr  out  AW  to bank write_addr
bank_read_addr  out  AW  to bank read_addr
bank_write_data  out  DW  to bank write_data
bank_read_data  in  DW  from bank read_data (combinational read)

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: all outputs 0. FSM in IDLE. Round-robin pointer set so A wins the first tie.
- FSM has two states, IDLE and ISSUE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: latch the winner's we/addr/wdata into a command register, go to ISSUE.
- Winner selection: single requester wins outright. If both request, the requester not granted last wins. The pointer updates on every grant.
- ISSUE lasts exactly 1 cycle, then returns to IDLE.
- ISSUE outputs: winner's gnt = 1.
- ISSUE, write command: bank_we = 1, bank_write_addr/bank_write_data driven from the command register. The write commits on the clk edge that ends ISSUE.
- ISSUE, read command: bank_read_addr driven from the command register. bank_read_data is registered into the winner's rdata on the edge ending ISSUE. The winner's rvalid pulses in the following cycle.
- Latency: req seen in IDLE at cycle N -> gnt in N+1 -> rvalid in N+2 for reads.
- Peak rate is one access per 2 cycles.
- Handshake: requester holds req and its command stable until it samples gnt. req still high in the cycle after gnt is a new request.
- Outputs outside ISSUE: bank_we = 0. bank_read_addr, bank_write_addr and bank_write_data hold their last values.
- x_rdata holds until that requester's next read completes. The other requester's rdata is never disturbed.
- Ordering: a write and a later read of the same address are always correctly ordered. The write commits before the read can issue.
- Simultaneous events: rvalid of a read may coincide with the next IDLE arbitration cycle. Both are handled independently.
- Reset mid-operation: rst_n low during ISSUE drops bank_we and gnt immediately. No write commits, the pending command is discarded and no rvalid is produced.

Optional Feature:
Macro: REGBANK_ARB_LOCK_EN.
- Defined: adds inputs a_lock and b_lock (1 bit each), sampled with req.
- A grant with lock = 1 reserves the bank. Only that requester may be granted until it is granted a command with lock = 0 (its final locked access).
- The lock is also released if the holder leaves req low for LOCK_TO consecutive cycles.
- When a lock is released, the round-robin pointer favours the other requester.
- Undefined: lock ports and logic are absent; pure round-robin.

Test Plan:
1. Release reset. A writes addr 3 = 0xAA -> a_gnt 1 cycle later, one bank_we pulse with addr 3/0xAA. A then reads 3 -> a_rvalid 2 cycles after req, a_rdata = 0xAA.
2. Same cycle: A writes 5 = 0x55 and B writes 5 = 0xA3 -> A granted first, then B. A subsequent read of 5 returns 0xA3.
3. A and B both hold read requests for 4 grants -> grants alternate A, B, A, B. Each rvalid goes only to the granted requester; the other rdata is unchanged.
4. Request held high after gnt -> treated as a second access, with a second gnt exactly 2 cycles after the first.
5. rst_n pulled low during a write's ISSUE cycle -> bank_we falls before the edge and the target register keeps its old value. All outputs read 0 and the first tie after reset goes to A.
6. With REGBANK_ARB_LOCK_EN, A locked read plus B req -> B is blocked until A's lock = 0 write is granted. Repeat with A idle instead -> B is granted after 16 idle cycles.
